xgemac_tx_arbiter: RTL and testbench

// Packet-granular round-robin arbiter sharing the XGEMAC packet TX interface between two sources.

---
 rtl/xgemac_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_xgemac_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgemac_tx_arbiter.sv
// Packet-granular round-robin arbiter between two packet sources and the
// XGEMAC pkt_tx_* port. One source owns the MAC from SOP to EOP, then a
// forced inter-packet gap runs before the next grant.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; arbitrate between SOP requests when arb_en is high
// BUSY  | grant held; forward the owner's words under pkt_tx_full gating
// GAP   | post-EOP idle time; no source is ready
//
// The IDLE arbitration cycle is itself one of the forced idle cycles, so
// GAP lasts IPG_CYCLES-1 cycles (skipped when IPG_CYCLES <= 1). This gives
// exactly IPG_CYCLES idle cycles between an EOP and the next SOP under
// continuous load.
module xgemac_tx_arbiter #(
    parameter int DATA_W     = 64,
    parameter int MOD_W      = 3,
    parameter int IPG_CYCLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              arb_en,
    input  logic [DATA_W-1:0] s0_tx_data,
    input  logic              s0_tx_val,
    input  logic              s0_tx_sop,
    input  logic              s0_tx_eop,
    input  logic [MOD_W-1:0]  s0_tx_mod,
    output logic              s0_tx_ready,
    input  logic [DATA_W-1:0] s1_tx_data,
    input  logic              s1_tx_val,
    input  logic              s1_tx_sop,
    input  logic              s1_tx_eop,
    input  logic [MOD_W-1:0]  s1_tx_mod,
    output logic              s1_tx_ready,
    output logic [DATA_W-1:0] pkt_tx_data,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [MOD_W-1:0]  pkt_tx_mod,
    input  logic              pkt_tx_full,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  s0_pkt_cnt,
    output logic [CNT_W-1:0]  s1_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam bit       USE_GAP  = (IPG_CYCLES > 1);
    localparam logic [3:0] GAP_LOAD = (IPG_CYCLES > 1) ? 4'(IPG_CYCLES - 2) : 4'd0;

    state_t              state, state_nxt;
    logic [1:0]          grant_nxt;
    logic                rr_ptr, rr_ptr_nxt;
    logic [3:0]          gap_cnt, gap_cnt_nxt;
    logic                req0, req1, pick1;
    logic                acc, acc_eop;
    logic [DATA_W-1:0]   in_data;
    logic                in_sop, in_eop;
    logic [MOD_W-1:0]    in_mod;

    // Handshake, source mux and accepted-word qualification.
    always_comb begin
        req0        = s0_tx_val & s0_tx_sop;
        req1        = s1_tx_val & s1_tx_sop;
        pick1       = rr_ptr ? req1 : ~req0;
        s0_tx_ready = (state == BUSY) & grant[0] & ~pkt_tx_full;
        s1_tx_ready = (state == BUSY) & grant[1] & ~pkt_tx_full;
        acc         = (s0_tx_val & s0_tx_ready) | (s1_tx_val & s1_tx_ready);
        in_data     = grant[1] ? s1_tx_data : s0_tx_data;
        in_sop      = grant[1] ? s1_tx_sop  : s0_tx_sop;
        in_eop      = grant[1] ? s1_tx_eop  : s0_tx_eop;
        in_mod      = grant[1] ? s1_tx_mod  : s0_tx_mod;
        acc_eop     = acc & in_eop;
    end

    // Next-state, grant, round-robin pointer and gap timer.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (arb_en && (req0 || req1)) begin
                    state_nxt = BUSY;
                    grant_nxt = pick1 ? 2'b10 : 2'b01;
                end
            end
            BUSY: begin
                if (acc_eop) begin
                    grant_nxt   = 2'b00;
                    rr_ptr_nxt  = ~grant[1];
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = USE_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state   <= IDLE;
            grant   <= 2'b00;
            rr_ptr  <= 1'b0;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Registered MAC datapath; data/mod hold when nothing is accepted.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_mod  <= '0;
        end else begin
            pkt_tx_val <= acc;
            pkt_tx_sop <= acc & in_sop;
            pkt_tx_eop <= acc_eop;
            if (acc) begin
                pkt_tx_data <= in_data;
                pkt_tx_mod  <= in_mod;
            end
        end
    end

    // Per-source forwarded-packet counters, wrapping.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            s0_pkt_cnt <= '0;
            s1_pkt_cnt <= '0;
        end else if (acc_eop) begin
            if (grant[0]) s0_pkt_cnt <= s0_pkt_cnt + CNT_W'(1);
            if (grant[1]) s1_pkt_cnt <= s1_pkt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// Directed bench for xgemac_tx_arbiter: queue-driven sources, output capture
// and hand-built expected word lists.
`timescale 1ns/100ps
module tb_xgemac_tx_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } word_t;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25 = 1'b1;
    logic        arb_en = 1'b1;
    logic [63:0] s0_tx_data = '0, s1_tx_data = '0;
    logic        s0_tx_val = 1'b0, s0_tx_sop = 1'b0, s0_tx_eop = 1'b0;
    logic        s1_tx_val = 1'b0, s1_tx_sop = 1'b0, s1_tx_eop = 1'b0;
    logic [2:0]  s0_tx_mod = '0, s1_tx_mod = '0;
    logic        s0_tx_ready, s1_tx_ready;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full = 1'b0;
    logic [1:0]  grant;
    logic [31:0] s0_pkt_cnt, s1_pkt_cnt;

    xgemac_tx_arbiter #(
        .DATA_W(64), .MOD_W(3), .IPG_CYCLES(2), .CNT_W(32)
    ) dut (
        .clk_156m25  (clk_156m25),
        .reset_156m25(reset_156m25),
        .arb_en      (arb_en),
        .s0_tx_data  (s0_tx_data),
        .s0_tx_val   (s0_tx_val),
        .s0_tx_sop   (s0_tx_sop),
        .s0_tx_eop   (s0_tx_eop),
        .s0_tx_mod   (s0_tx_mod),
        .s0_tx_ready (s0_tx_ready),
        .s1_tx_data  (s1_tx_data),
        .s1_tx_val   (s1_tx_val),
        .s1_tx_sop   (s1_tx_sop),
        .s1_tx_eop   (s1_tx_eop),
        .s1_tx_mod   (s1_tx_mod),
        .s1_tx_ready (s1_tx_ready),
        .pkt_tx_data (pkt_tx_data),
        .pkt_tx_val  (pkt_tx_val),
        .pkt_tx_sop  (pkt_tx_sop),
        .pkt_tx_eop  (pkt_tx_eop),
        .pkt_tx_mod  (pkt_tx_mod),
        .pkt_tx_full (pkt_tx_full),
        .grant       (grant),
        .s0_pkt_cnt  (s0_pkt_cnt),
        .s1_pkt_cnt  (s1_pkt_cnt)
    );

    always #3.2 clk_156m25 = ~clk_156m25;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    acc_cnt = 0;
    word_t q0[$], q1[$], out_q[$], exp_q[$];
    int    out_cyc[$], acc_cyc[$];
    logic  hs0 = 1'b0, hs1 = 1'b0, rel_pending = 1'b0;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t mkword(input int src, input int pkt, input int w, input int nw, input int mod);
        word_t x;
        x.data = 64'h1000_0000_0000_0000 | (64'(src) << 40) | (64'(pkt) << 20) | 64'(w);
        x.sop  = (w == 0);
        x.eop  = (w == nw - 1);
        x.mod  = x.eop ? 3'(mod) : 3'd0;
        return x;
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int nw, input int mod);
        for (int w = 0; w < nw; w++) begin
            if (src == 0) q0.push_back(mkword(src, pkt, w, nw, mod));
            else          q1.push_back(mkword(src, pkt, w, nw, mod));
        end
    endtask

    task automatic exp_pkt(input int src, input int pkt, input int nw, input int mod);
        for (int w = 0; w < nw; w++) exp_q.push_back(mkword(src, pkt, w, nw, mod));
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        acc_cyc.delete();
        exp_q.delete();
        acc_cnt = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_156m25);
            if (q0.size() == 0 && q1.size() == 0) begin
                repeat (4) @(negedge clk_156m25);
                return;
            end
        end
        check_val("drain_timeout", 72'(1), 72'(0));
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_156m25);
            #1;
            if (acc_cnt >= n) return;
        end
        check_val("accept_timeout", 72'(acc_cnt), 72'(n));
    endtask

    task automatic check_out(input string tag);
        check_val({tag, "_count"}, 72'(out_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check_val(tag, 72'(out_q[i]), 72'(exp_q[i]));
    endtask

    // Cycle counter: cycle N spans posedge N to posedge N+1.
    always @(posedge clk_156m25) cyc++;

    // Mid-cycle monitor: handshakes, MAC output capture, grant release after EOP.
    always @(negedge clk_156m25) begin
        word_t tmp;
        hs0 = s0_tx_val & s0_tx_ready;
        hs1 = s1_tx_val & s1_tx_ready;
        if (hs0 | hs1) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
        if (pkt_tx_val) begin
            tmp = {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod};
            out_q.push_back(tmp);
            out_cyc.push_back(cyc);
        end
        if (rel_pending) check_val("grant_released", 72'(grant), 72'(0));
        rel_pending = (hs0 & s0_tx_eop) | (hs1 & s1_tx_eop);
    end

    // Source drivers: present queue head, advance on a completed handshake.
    always @(posedge clk_156m25) begin
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            s0_tx_val = 1'b1;
            {s0_tx_data, s0_tx_sop, s0_tx_eop, s0_tx_mod} = q0[0];
        end else begin
            s0_tx_val = 1'b0; s0_tx_sop = 1'b0; s0_tx_eop = 1'b0;
        end
        if (q1.size() > 0) begin
            s1_tx_val = 1'b1;
            {s1_tx_data, s1_tx_sop, s1_tx_eop, s1_tx_mod} = q1[0];
        end else begin
            s1_tx_val = 1'b0; s1_tx_sop = 1'b0; s1_tx_eop = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk_156m25);
        #2 reset_156m25 = 1'b0;

        // Reset state
        @(negedge clk_156m25);
        check_val("rst_grant", 72'(grant), 72'(0));
        check_val("rst_out", 72'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}), 72'(0));
        check_val("rst_cnt", 72'({s0_pkt_cnt, s1_pkt_cnt}), 72'(0));
        check_val("rst_ready", 72'({s0_tx_ready, s1_tx_ready}), 72'(0));

        // Both sources loaded: strict alternation starting at src0, 2-cycle gaps
        clear_logs();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, p, 2, p + 1);
            push_pkt(1, p, 2, p + 2);
            exp_pkt(0, p, 2, p + 1);
            exp_pkt(1, p, 2, p + 2);
        end
        wait_drain();
        check_out("rr_order");
        for (int i = 1; i + 1 < out_cyc.size(); i += 2)
            check_val("ipg", 72'(out_cyc[i+1] - out_cyc[i] - 1), 72'(2));
        check_val("rr_cnt0", 72'(s0_pkt_cnt), 72'(4));
        check_val("rr_cnt1", 72'(s1_pkt_cnt), 72'(4));

        // Single src0 3-word packet, 1-cycle latency
        clear_logs();
        push_pkt(0, 10, 3, 4);
        exp_pkt(0, 10, 3, 4);
        wait_drain();
        check_out("single");
        check_val("single_acc_count", 72'(acc_cyc.size()), 72'(3));
        for (int i = 0; i < 3 && i < acc_cyc.size() && i < out_cyc.size(); i++)
            check_val("latency", 72'(out_cyc[i] - acc_cyc[i]), 72'(1));
        check_val("single_cnt0", 72'(s0_pkt_cnt), 72'(5));

        // Backpressure: full for 3 cycles after the second word
        clear_logs();
        push_pkt(0, 11, 6, 7);
        exp_pkt(0, 11, 6, 7);
        wait_acc(2);
        @(posedge clk_156m25);
        #2 pkt_tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_156m25);
            check_val("full_ready", 72'(s0_tx_ready), 72'(0));
        end
        @(posedge clk_156m25);
        #2 pkt_tx_full = 1'b0;
        wait_drain();
        check_out("full");
        if (out_cyc.size() == 6)
            check_val("full_span", 72'(out_cyc[5] - out_cyc[0]), 72'(8));
        else
            check_val("full_span_words", 72'(out_cyc.size()), 72'(6));
        check_val("full_cnt0", 72'(s0_pkt_cnt), 72'(6));

        // One-word packet on src1, mod=5
        clear_logs();
        push_pkt(1, 12, 1, 5);
        exp_pkt(1, 12, 1, 5);
        wait_drain();
        check_out("oneword");
        check_val("oneword_grant", 72'(grant), 72'(0));
        check_val("oneword_cnt1", 72'(s1_pkt_cnt), 72'(5));

        // Reset on word 2 of a 4-word src1 packet
        clear_logs();
        push_pkt(1, 13, 4, 3);
        wait_acc(1);
        @(posedge clk_156m25);
        #2 reset_156m25 = 1'b1;
        @(posedge clk_156m25);
        #2 reset_156m25 = 1'b0;
        q1.delete();
        @(negedge clk_156m25);
        check_val("mid_rst_grant", 72'(grant), 72'(0));
        check_val("mid_rst_out", 72'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}), 72'(0));
        check_val("mid_rst_cnt", 72'({s0_pkt_cnt, s1_pkt_cnt}), 72'(0));
        check_val("mid_rst_ready", 72'({s0_tx_ready, s1_tx_ready}), 72'(0));
        clear_logs();
        push_pkt(1, 14, 2, 1);
        push_pkt(0, 14, 2, 2);
        exp_pkt(0, 14, 2, 2);
        exp_pkt(1, 14, 2, 1);
        wait_drain();
        check_out("post_rst");
        check_val("post_rst_cnt", 72'({s0_pkt_cnt, s1_pkt_cnt}), {8'h0, 32'd1, 32'd1});

        // arb_en dropped during a src0 packet with src1 waiting
        clear_logs();
        push_pkt(0, 15, 4, 6);
        push_pkt(1, 15, 2, 0);
        exp_pkt(0, 15, 4, 6);
        wait_acc(1);
        arb_en = 1'b0;
        repeat (20) @(negedge clk_156m25);
        check_out("arb_off");
        check_val("arb_off_grant", 72'(grant), 72'(0));
        check_val("arb_off_ready1", 72'(s1_tx_ready), 72'(0));
        check_val("arb_off_pending", 72'(q1.size()), 72'(2));
        check_val("arb_off_cnt", 72'({s0_pkt_cnt, s1_pkt_cnt}), {8'h0, 32'd2, 32'd1});
        arb_en = 1'b1;
        exp_pkt(1, 15, 2, 0);
        wait_drain();
        check_out("arb_on");
        check_val("arb_on_cnt1", 72'(s1_pkt_cnt), 72'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
